// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem req/gnt/rvalid handshake, IF/ID register, one-entry skid.
// Optional performance counters are enabled with the IF_STAGE_PERF_EN macro.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [5:0]  id_opcode_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_drop_cnt_o
`endif
);

    // state | meaning
    // RUN   | nothing outstanding
    // WAIT  | one fetch outstanding, result wanted
    // DROP  | one fetch outstanding, result to be discarded
    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic        skid_valid_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;

    logic        free;
    logic        grant;
    logic        rsp_take;
    logic        load_id_rsp;
    logic        load_skid;
    logic        drain;

    assign imem_addr_o = pc_q;
    assign id_opcode_o = id_instr_o[31:26];

    always_comb begin
        free        = !id_valid_o || !stall_i;
        imem_req_o  = 1'b0;
        grant       = 1'b0;
        rsp_take    = 1'b0;
        load_id_rsp = 1'b0;
        load_skid   = 1'b0;
        drain       = 1'b0;
        state_d     = state_q;
        pc_d        = pc_q;

        // rst_n gates the request so the memory never sees one during reset
        imem_req_o = rst_n && !redirect_i && !skid_valid_q && free &&
                     ((state_q == S_RUN) || ((state_q == S_WAIT) && imem_rvalid_i));
        grant      = imem_req_o && imem_gnt_i;

        rsp_take    = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
        load_id_rsp = rsp_take && !skid_valid_q && free;
        load_skid   = rsp_take && !load_id_rsp;
        drain       = skid_valid_q && free && !redirect_i;

        if (redirect_i) begin
            pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid_i ? S_RUN : S_DROP;
                S_DROP:  state_d = imem_rvalid_i ? S_RUN : S_DROP;
                default: state_d = S_RUN;
            endcase
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            case (state_q)
                S_RUN:   state_d = grant ? S_WAIT : S_RUN;
                S_WAIT:  state_d = (imem_rvalid_i && !grant) ? S_RUN : S_WAIT;
                S_DROP:  state_d = imem_rvalid_i ? S_RUN : S_DROP;
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // IF/ID register: skid has priority so program order is kept
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o    <= 1'b0;
            id_instr_o    <= 32'h0;
            id_pc_o       <= 32'h0;
            id_pc_plus4_o <= 32'd4;
        end else if (redirect_i) begin
            id_valid_o <= 1'b0;
        end else if (drain) begin
            id_valid_o    <= 1'b1;
            id_instr_o    <= skid_instr_q;
            id_pc_o       <= skid_pc_q;
            id_pc_plus4_o <= skid_pc_q + 32'd4;
        end else if (load_id_rsp) begin
            id_valid_o    <= 1'b1;
            id_instr_o    <= imem_rdata_i;
            id_pc_o       <= pc_q - 32'd4;
            id_pc_plus4_o <= pc_q;
        end else if (!stall_i) begin
            id_valid_o <= 1'b0;
        end
    end

    // pc_q has already advanced past the outstanding fetch, so its address is pc_q - 4
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else if (redirect_i) begin
            skid_valid_q <= 1'b0;
        end else if (load_skid) begin
            skid_valid_q <= 1'b1;
            skid_instr_q <= imem_rdata_i;
            skid_pc_q    <= pc_q - 32'd4;
        end else if (drain) begin
            skid_valid_q <= 1'b0;
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic fetch_evt;
    logic drop_evt;

    assign fetch_evt = rsp_take;
    assign drop_evt  = imem_rvalid_i &&
                       ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect_i));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_o <= 32'h0;
            perf_drop_cnt_o  <= 32'h0;
        end else begin
            if (fetch_evt) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (drop_evt)  perf_drop_cnt_o  <= perf_drop_cnt_o + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall/skid, redirects, PC wrap, async reset.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [5:0]  id_opcode_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_drop_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic        hs;
    logic [31:0] hs_addr;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_opcode_o   (id_opcode_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o)
`ifdef IF_STAGE_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_drop_cnt_o  (perf_drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], a[25:0] ^ 26'h2AB_CDEF};
    endfunction

    // memory model: grant always, response lat cycles after the grant edge
    always @(posedge clk_i) begin
        hs      = imem_req_o & imem_gnt_i;
        hs_addr = imem_addr_o;
        #1;
        imem_rvalid_i = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (hs) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = hs_addr;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(paddr);
                    pend          = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        cyc(2);
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_instr", id_instr_o, 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_pc4", id_pc_plus4_o, 32'h4);
        chk("rst_addr", imem_addr_o, 32'h0);

        // streaming with 1-cycle memory; release at negedge = cycle 0
        rst_n = 1'b1;
        #1;
        chk("c0_req", {31'h0, imem_req_o}, 32'h1);
        chk("c0_addr", imem_addr_o, 32'h0);
        cyc(1);
        chk("c1_addr", imem_addr_o, 32'h4);
        chk("c1_valid", {31'h0, id_valid_o}, 32'h0);
        cyc(1);
        chk("c2_valid", {31'h0, id_valid_o}, 32'h1);
        chk("c2_pc", id_pc_o, 32'h0);
        chk("c2_instr", id_instr_o, mem_word(32'h0));
        chk("c2_opc", {26'h0, id_opcode_o}, 32'h0);
        chk("c2_pc4", id_pc_plus4_o, 32'h4);
        chk("c2_addr", imem_addr_o, 32'h8);
        cyc(1);
        chk("c3_pc", id_pc_o, 32'h4);
        chk("c3_opc", {26'h0, id_opcode_o}, 32'h1);
        cyc(1);
        chk("c4_pc", id_pc_o, 32'h8);
        chk("c4_req", {31'h0, imem_req_o}, 32'h1);
        chk("c4_addr", imem_addr_o, 32'h10);

        // stall while the response for 0xC is in flight
        stall_i = 1'b1;
        #1;
        chk("c4_stall_req", {31'h0, imem_req_o}, 32'h0);
        cyc(1);
        chk("c5_pc", id_pc_o, 32'h8);
        chk("c5_instr", id_instr_o, mem_word(32'h8));
        chk("c5_req", {31'h0, imem_req_o}, 32'h0);
        cyc(1);
        chk("c6_pc", id_pc_o, 32'h8);
        chk("c6_valid", {31'h0, id_valid_o}, 32'h1);
        cyc(1);
        chk("c7_pc", id_pc_o, 32'h8);
        chk("c7_req", {31'h0, imem_req_o}, 32'h0);
        stall_i = 1'b0;
        #1;
        chk("c7_skidfull_req", {31'h0, imem_req_o}, 32'h0);
        cyc(1);
        chk("c8_pc", id_pc_o, 32'hC);
        chk("c8_instr", id_instr_o, mem_word(32'hC));
        chk("c8_req", {31'h0, imem_req_o}, 32'h1);
        chk("c8_addr", imem_addr_o, 32'h10);
        cyc(1);
        chk("c9_valid", {31'h0, id_valid_o}, 32'h0);
        cyc(1);
        chk("c10_pc", id_pc_o, 32'h10);
        chk("c10_valid", {31'h0, id_valid_o}, 32'h1);

        // async reset between edges
        #2;
        rst_n = 1'b0;
        imem_rvalid_i = 1'b0;
        pend = 1'b0;
        #1;
        chk("arst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("arst_pc", id_pc_o, 32'h0);
        chk("arst_instr", id_instr_o, 32'h0);
        chk("arst_pc4", id_pc_plus4_o, 32'h4);
        chk("arst_req", {31'h0, imem_req_o}, 32'h0);
        chk("arst_addr", imem_addr_o, 32'h0);
        lat = 3;
        cyc(1);
        rst_n = 1'b1;
        #1;
        chk("r0_req", {31'h0, imem_req_o}, 32'h1);
        chk("r0_addr", imem_addr_o, 32'h0);

        // redirect with an outstanding fetch, latency 3
        cyc(1);
        chk("r1_req", {31'h0, imem_req_o}, 32'h0);
        cyc(3);
        chk("r4_pc", id_pc_o, 32'h0);
        chk("r4_valid", {31'h0, id_valid_o}, 32'h1);
        cyc(3);
        chk("r7_pc", id_pc_o, 32'h4);
        chk("r7_req", {31'h0, imem_req_o}, 32'h0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        cyc(1);
        redirect_i = 1'b0;
        #1;
        chk("r8_valid", {31'h0, id_valid_o}, 32'h0);
        chk("r8_req", {31'h0, imem_req_o}, 32'h0);
        chk("r8_addr", imem_addr_o, 32'h100);
        cyc(1);
        chk("r9_req", {31'h0, imem_req_o}, 32'h0);
        cyc(1);
        chk("r10_req", {31'h0, imem_req_o}, 32'h1);
        chk("r10_addr", imem_addr_o, 32'h100);
        chk("r10_valid", {31'h0, id_valid_o}, 32'h0);
        cyc(1);
        chk("r11_valid", {31'h0, id_valid_o}, 32'h0);
        cyc(3);
        chk("r14_pc", id_pc_o, 32'h100);
        chk("r14_instr", id_instr_o, mem_word(32'h100));
        chk("r14_pc4", id_pc_plus4_o, 32'h104);

        // redirect coincident with rvalid while stalled
        lat = 1;
        stall_i = 1'b1;
        cyc(1);
        chk("r15_pc", id_pc_o, 32'h100);
        chk("r15_valid", {31'h0, id_valid_o}, 32'h1);
        cyc(1);
        chk("r16_pc", id_pc_o, 32'h100);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        cyc(1);
        redirect_i = 1'b0;
        #1;
        chk("r17_valid", {31'h0, id_valid_o}, 32'h0);
        chk("r17_addr", imem_addr_o, 32'h200);
        chk("r17_req", {31'h0, imem_req_o}, 32'h1);
`ifdef IF_STAGE_PERF_EN
        chk("r17_drops", perf_drop_cnt_o, 32'd2);
`endif
        cyc(2);
        chk("r19_pc", id_pc_o, 32'h200);
        chk("r19_instr", id_instr_o, mem_word(32'h200));

        // PC wrap
        stall_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cyc(1);
        redirect_i = 1'b0;
        #1;
        chk("r20_req", {31'h0, imem_req_o}, 32'h1);
        chk("r20_addr", imem_addr_o, 32'hFFFF_FFFC);
        chk("r20_valid", {31'h0, id_valid_o}, 32'h0);
        cyc(1);
        chk("r21_addr", imem_addr_o, 32'h0);
        cyc(1);
        chk("r22_pc", id_pc_o, 32'hFFFF_FFFC);
        chk("r22_pc4", id_pc_plus4_o, 32'h0);
        chk("r22_instr", id_instr_o, mem_word(32'hFFFF_FFFC));
`ifdef IF_STAGE_PERF_EN
        chk("r22_fetches", perf_fetch_cnt_o, 32'd5);
        chk("r22_drops", perf_drop_cnt_o, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, fetches 32-bit instructions from instruction memory over a request/grant/response handshake, and presents them with their PC in the IF/ID register to the instruction decoder (`id_opcode_o` feeds the decoder opcode input). It supports stall from the hazard unit and redirect (branch/jump) with discard of stale in-flight fetches. A one-entry skid buffer ensures no response is ever lost.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, equals `pc_q`.
- `imem_gnt_i` in 1: request accepted in a cycle with `req & gnt`.
- `imem_rvalid_i` in 1: response valid. Responses arrive in order, at least 1 cycle after grant, at most one outstanding.
- `imem_rdata_i` in 32: instruction data.
- `redirect_i` in 1: branch/jump taken, flush and refetch.
- `redirect_pc_i` in 32: new PC. Bits [1:0] are forced to 00.
- `stall_i` in 1: ID stage holds, so the IF/ID register must not change.
- `id_valid_o` out 1: IF/ID register holds a valid instruction.
- `id_instr_o` out 32: instruction.
- `id_opcode_o` out 6: `id_instr_o[31:26]`.
- `id_pc_o` out 32: address of `id_instr_o`.
- `id_pc_plus4_o` out 32: `id_pc_o + 4`.

## Operation
- **FSM states.**
  - RUN: nothing outstanding.
  - WAIT: one fetch outstanding, result wanted.
  - DROP: one fetch outstanding, result to be discarded.
- **Slot free condition:** `free = !id_valid_o | !stall_i`.
- **Request.** `imem_req_o = !redirect_i & skid empty & free & (RUN | (WAIT & imem_rvalid_i))`. This permits back-to-back fetch in the cycle a response returns.
- **Grant.** On `req & gnt`: `pc_q <= pc_q + 4` (32-bit wrap, 0xFFFF_FFFC → 0), next state WAIT.
- **WAIT with `imem_rvalid_i`:**
  - If skid is empty and `free`, load IF/ID with {instr, pc}.
  - Otherwise load skid.
  - Next state is RUN, unless a new grant occurs the same cycle, in which case stay WAIT.
- **Skid drain.** If skid is full and `free`, skid moves into IF/ID and the skid is cleared.
- **IF/ID clear.** If `!stall_i` and there is no new data, `id_valid_o <= 0`.
- **Redirect** (highest priority, overrides stall):
  - `pc_q <= {redirect_pc_i[31:2],2'b00}`.
  - `id_valid_o <= 0`; skid cleared.
  - No request is issued that cycle.
  - State: RUN → RUN. WAIT → DROP, or RUN if `imem_rvalid_i` is present that cycle (that response is discarded). DROP → DROP, or RUN if `imem_rvalid_i`.
- **DROP with `imem_rvalid_i`:** data discarded, next state RUN.
- **Stall.** While stalled, IF/ID contents are held bit-exact.
- **Reset values:**
  - `pc_q = RESET_PC`, state RUN.
  - `id_valid_o = 0`; `id_instr_o`, `id_pc_o` = 0; `id_pc_plus4_o` = 4.
  - Skid empty.
  - `imem_req_o` is forced 0 while `rst_n` is low.
- **Reset mid-operation:** any outstanding response after reset release is illegal. The memory is reset together with this block.

## Timing
- With a single-cycle memory (gnt same cycle, rvalid next cycle):
  - Request in cycle N gives `id_valid_o` high in cycle N+2.
  - Sustained throughput is 1 instruction/cycle.
- Redirect in cycle N: IF/ID is invalid in N+1, `imem_addr_o = redirect_pc` in N+1 (RUN case), and the target instruction is valid in N+3.
- Outputs `id_*` come directly from registers. `imem_req_o` is combinational from state and inputs, with no combinational path from `imem_rdata_i`.

## Configuration
- Macro `IF_STAGE_PERF_EN`. When defined, the block adds the following outputs, both reset to 0 and wrapping at 2^32:
  - `perf_fetch_cnt_o` (32): increments per response delivered to IF/ID or skid.
  - `perf_drop_cnt_o` (32): increments per response discarded in DROP or on the redirect cycle.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

## Test plan
- **Reset + streaming.** Release reset with `RESET_PC=0` and a 1-cycle memory → addresses 0,4,8,… issued each cycle; `id_pc_o` 0,4,8 from cycle 2; `id_opcode_o` = data[31:26].
- **Stall hold.** Assert `stall_i` for 3 cycles while a response is in flight → IF/ID unchanged, skid holds next instr, `imem_req_o` low; after release, instructions arrive in order with no loss or duplication.
- **Redirect with outstanding fetch.** Memory latency 3, redirect to 0x100 one cycle after grant of 0x8 → 0x8 data discarded (drop count +1 if `IF_STAGE_PERF_EN` is defined), next request 0x100, `id_pc_o`=0x100.
- **Redirect coincident with rvalid and stall.** Redirect to 0x203 → response dropped, `id_valid_o`=0 next cycle despite stall, fetch address 0x200.
- **PC wrap.** Redirect to 0xFFFF_FFFC → next fetch address 0x0, `id_pc_plus4_o`=0x0.
- **Async reset mid-stream.** Pull `rst_n` low between edges → outputs reach reset values immediately; after release, fetch restarts at `RESET_PC`.
